// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared types and helpers for the score/lives commit logic.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_LIFE = 2'd2
    } state_t;

    typedef struct packed {
        logic bottom;
        logic trap;
        logic credit;
        logic bumper;
        logic bad;
        logic good;
    } flags_t;

    // Binary 0..99 to two BCD digits, tens in [7:4], ones in [3:0].
    function automatic logic [7:0] to_bcd2(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adder
// Description : Combinational single-digit BCD adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adder
    import score_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic [3:0] i_addend,
    input  logic       i_carry,
    output logic [3:0] o_sum,
    output logic       o_carry
);

    logic [4:0] w_raw;

    always_comb begin
        w_raw = {1'b0, i_digit} + {1'b0, i_addend} + {4'b0000, i_carry};
        if (w_raw > 5'(BCD_MAX)) begin
            o_sum   = 4'(w_raw - 5'd10);
            o_carry = 1'b1;
        end else begin
            o_sum   = w_raw[3:0];
            o_carry = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_manager.sv
`default_nettype none
// ============================================================================
// Module      : score_manager
// Description : Accumulates per-frame collision events and commits them to a
//               BCD score and lives counter at each frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module score_manager
    import score_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int POINTS_GOOD   = 5,
    parameter int POINTS_BUMPER = 2,
    parameter int POINTS_CREDIT = 10,
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  newGame,
    input  logic                  collisionBallObstacleGood,
    input  logic                  collisionBallObstacleBad,
    input  logic                  collisionBallBumper,
    input  logic                  collisionBallCredit,
    input  logic                  collisionBallTrap,
    input  logic                  collisionBallBottom,
    output logic [DIGITS*4-1:0]   score,
    output logic [3:0]            lives,
    output logic                  gameOver,
    output logic                  ballLost,
    output logic                  busy
);

    localparam int                  c_IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX   = c_IDX_W'(DIGITS - 1);
    localparam logic [3:0]          c_INIT_LIVES = 4'(INIT_LIVES);
    localparam logic [3:0]          c_MAX_LIVES  = 4'(MAX_LIVES);

    state_t             r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [3:0]         r_digits [DIGITS];
    logic [3:0]         r_addend0;
    logic [3:0]         r_addend1;
    flags_t             r_flags;
    logic               r_snapLoss;
    logic               r_snapGain;
    logic               r_deferred;
    logic [3:0]         r_lives;
    logic               r_gameOver;
    logic               r_ballLost;

    flags_t             w_pulses;
    logic               w_snap;
    int                 w_inc;
    logic [7:0]         w_incBcd;
    logic [3:0]         w_curDigit;
    logic [3:0]         w_curAddend;
    logic [3:0]         w_sum;
    logic               w_carryOut;

    // Collisions are dropped entirely once the game is over.
    always_comb begin
        w_pulses        = '0;
        w_pulses.good   = collisionBallObstacleGood;
        w_pulses.bad    = collisionBallObstacleBad;
        w_pulses.bumper = collisionBallBumper;
        w_pulses.credit = collisionBallCredit;
        w_pulses.trap   = collisionBallTrap;
        w_pulses.bottom = collisionBallBottom;
        if (r_gameOver) begin
            w_pulses = '0;
        end
    end

    assign w_snap = (r_state == ST_IDLE) && (startOfFrame || r_deferred);

    always_comb begin
        w_inc = 0;
        if (r_flags.good)   w_inc = w_inc + POINTS_GOOD;
        if (r_flags.bumper) w_inc = w_inc + POINTS_BUMPER;
        if (r_flags.credit) w_inc = w_inc + POINTS_CREDIT;
        w_incBcd = to_bcd2(w_inc);
    end

    always_comb begin
        w_curDigit  = r_digits[r_idx];
        w_curAddend = 4'd0;
        if (r_idx == c_IDX_W'(0)) begin
            w_curAddend = r_addend0;
        end else if (r_idx == c_IDX_W'(1)) begin
            w_curAddend = r_addend1;
        end
    end

    bcd_digit_adder u_adder (
        .i_digit  (w_curDigit),
        .i_addend (w_curAddend),
        .i_carry  (r_carry),
        .o_sum    (w_sum),
        .o_carry  (w_carryOut)
    );

    always_ff @(posedge clk) begin
        if (!resetN || newGame) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_addend0  <= 4'd0;
            r_addend1  <= 4'd0;
            r_flags    <= '0;
            r_snapLoss <= 1'b0;
            r_snapGain <= 1'b0;
            r_deferred <= 1'b0;
            r_lives    <= c_INIT_LIVES;
            r_gameOver <= 1'b0;
            r_ballLost <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_digits[i] <= 4'd0;
            end
        end else begin
            r_ballLost <= 1'b0;
            // A pulse coincident with the snapshot lands in the new frame.
            r_flags    <= (w_snap ? flags_t'('0) : r_flags) | w_pulses;
            if (startOfFrame && (r_state != ST_IDLE)) begin
                r_deferred <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_snap) begin
                        r_deferred <= 1'b0;
                        r_snapLoss <= r_flags.bad | r_flags.trap | r_flags.bottom;
                        r_snapGain <= r_flags.credit;
                        r_addend0  <= w_incBcd[3:0];
                        r_addend1  <= w_incBcd[7:4];
                        r_carry    <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= ST_ADD;
                    end
                end

                ST_ADD: begin
                    r_digits[r_idx] <= w_sum;
                    r_carry         <= w_carryOut;
                    if (r_idx == c_LAST_IDX) begin
                        // Overflow out of the top digit pins the score at all nines.
                        if (w_carryOut) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                r_digits[i] <= 4'(BCD_MAX);
                            end
                        end
                        r_state <= ST_LIFE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end

                ST_LIFE: begin
                    if (r_snapLoss && !r_snapGain && (r_lives != 4'd0)) begin
                        r_lives    <= r_lives - 4'd1;
                        r_ballLost <= 1'b1;
                        if (r_lives == 4'd1) begin
                            r_gameOver <= 1'b1;
                        end
                    end else if (r_snapGain && !r_snapLoss && (r_lives < c_MAX_LIVES)) begin
                        r_lives <= r_lives + 4'd1;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pack
        assign score[gi*4 +: 4] = r_digits[gi];
    end

    assign lives    = r_lives;
    assign gameOver = r_gameOver;
    assign ballLost = r_ballLost;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_score_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_manager
// Description : Self-checking bench for score_manager (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_manager;

    localparam int DIGITS    = 4;
    localparam int SCORE_MAX = 9999;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic newGame = 1'b0;
    logic cGood = 1'b0, cBad = 1'b0, cBumper = 1'b0;
    logic cCredit = 1'b0, cTrap = 1'b0, cBottom = 1'b0;
    logic [DIGITS*4-1:0] score;
    logic [3:0] lives;
    logic gameOver, ballLost, busy;

    always #5 clk = ~clk;

    score_manager #(
        .DIGITS(DIGITS), .POINTS_GOOD(5), .POINTS_BUMPER(2), .POINTS_CREDIT(10),
        .INIT_LIVES(3), .MAX_LIVES(5)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newGame(newGame),
        .collisionBallObstacleGood(cGood), .collisionBallObstacleBad(cBad),
        .collisionBallBumper(cBumper), .collisionBallCredit(cCredit),
        .collisionBallTrap(cTrap), .collisionBallBottom(cBottom),
        .score(score), .lives(lives), .gameOver(gameOver),
        .ballLost(ballLost), .busy(busy)
    );

    // Event mask bits: 0 good, 1 bad, 2 bumper, 3 credit, 4 trap, 5 bottom
    typedef struct {
        logic [5:0] mask;
        int         expScore;
        int         expLives;
        bit         expGo;
    } vec_t;

    vec_t vecs [12];
    int   nPass = 0;
    int   nTotal = 0;

    // Frame-level reference model
    int         m_score;
    int         m_lives;
    bit         m_go;
    logic [5:0] m_flags;

    task automatic check(input string name, input int act, input int exp);
        nTotal++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step(input logic [5:0] p, input logic sof, input logic ng);
        {cBottom, cTrap, cCredit, cBumper, cBad, cGood} = p;
        startOfFrame = sof;
        newGame = ng;
        @(posedge clk);
        #1;
        {cBottom, cTrap, cCredit, cBumper, cBad, cGood} = 6'd0;
        startOfFrame = 1'b0;
        newGame = 1'b0;
    endtask

    task automatic model_reset();
        m_score = 0;
        m_lives = 3;
        m_go    = 1'b0;
        m_flags = 6'd0;
    endtask

    task automatic do_new_game();
        step(6'd0, 1'b0, 1'b1);
        model_reset();
        check("newgame_score", score, 0);
        check("newgame_lives", lives, 3);
        check("newgame_gameover", gameOver, 0);
        check("newgame_busy", busy, 0);
    endtask

    // Pulse the mask events, then startOfFrame (with sofP pulses in that same cycle),
    // and check the whole commit timeline against the model.
    task automatic run_frame(input logic [5:0] mask, input logic [5:0] sofP);
        logic [5:0] snap;
        int  inc, expScore, expLives;
        bit  expGo, expBl, loss, gain;
        for (int b = 0; b < 6; b++) begin
            if (mask[b]) begin
                step(6'(1 << b), 1'b0, 1'b0);
                if (!m_go) m_flags[b] = 1'b1;
            end
        end
        step(6'd0, 1'b0, 1'b0);
        snap = m_flags;
        m_flags = m_go ? 6'd0 : sofP;
        step(sofP, 1'b1, 1'b0);

        inc = (snap[0] ? 5 : 0) + (snap[2] ? 2 : 0) + (snap[3] ? 10 : 0);
        expScore = (m_score + inc > SCORE_MAX) ? SCORE_MAX : m_score + inc;
        loss = snap[1] | snap[4] | snap[5];
        gain = snap[3];
        expLives = m_lives;
        expGo = m_go;
        expBl = 1'b0;
        if (loss && !gain) begin
            expLives = expLives - 1;
            expBl = 1'b1;
            if (expLives == 0) expGo = 1'b1;
        end else if (gain && !loss && expLives < 5) begin
            expLives = expLives + 1;
        end

        for (int k = 1; k <= 5; k++) begin
            check("busy_in_commit", busy, 1);
            if (k == 5) begin
                check("score_at_T+5", score, to_bcd(expScore));
                check("lives_still_old_at_T+5", lives, m_lives);
                check("ballLost_low_at_T+5", ballLost, 0);
            end
            step(6'd0, 1'b0, 1'b0);
        end
        check("busy_low_at_T+6", busy, 0);
        check("lives_at_T+6", lives, expLives);
        check("gameOver_at_T+6", gameOver, expGo);
        check("ballLost_at_T+6", ballLost, expBl);
        check("score_at_T+6", score, to_bcd(expScore));
        step(6'd0, 1'b0, 1'b0);
        check("ballLost_low_at_T+7", ballLost, 0);

        m_score = expScore;
        m_lives = expLives;
        m_go    = expGo;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [5:0] mask;
        logic [5:0] sofP;

        vecs[0]  = '{6'b000101, 'h0007, 3, 1'b0};
        vecs[1]  = '{6'b001000, 'h0017, 4, 1'b0};
        vecs[2]  = '{6'b000010, 'h0017, 3, 1'b0};
        vecs[3]  = '{6'b001010, 'h0027, 3, 1'b0};
        vecs[4]  = '{6'b000000, 'h0027, 3, 1'b0};
        vecs[5]  = '{6'b001000, 'h0037, 4, 1'b0};
        vecs[6]  = '{6'b001000, 'h0047, 5, 1'b0};
        vecs[7]  = '{6'b001000, 'h0057, 5, 1'b0};
        vecs[8]  = '{6'b001101, 'h0074, 5, 1'b0};
        vecs[9]  = '{6'b110000, 'h0074, 4, 1'b0};
        vecs[10] = '{6'b010010, 'h0074, 3, 1'b0};
        vecs[11] = '{6'b000001, 'h0079, 3, 1'b0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        check("reset_score", score, 0);
        check("reset_lives", lives, 3);
        check("reset_gameOver", gameOver, 0);
        check("reset_ballLost", ballLost, 0);
        check("reset_busy", busy, 0);

        // Table-driven frames
        do_new_game();
        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i].mask, 6'd0);
            check("table_score", score, vecs[i].expScore);
            check("table_lives", lives, vecs[i].expLives);
            check("table_gameOver", gameOver, vecs[i].expGo);
        end

        // Bumper coincident with startOfFrame belongs to the next frame
        do_new_game();
        run_frame(6'b000001, 6'b000100);
        check("coincident_first_score", score, 'h0005);
        run_frame(6'b000000, 6'd0);
        check("coincident_next_score", score, 'h0007);

        // newGame aborts a commit mid-ADD
        run_frame(6'b001000, 6'd0);
        check("pre_abort_lives", lives, 4);
        step(6'b000001, 1'b0, 1'b0);
        step(6'd0, 1'b1, 1'b0);
        step(6'd0, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b1);
        check("abort_score", score, 0);
        check("abort_lives", lives, 3);
        check("abort_gameOver", gameOver, 0);
        check("abort_busy", busy, 0);
        model_reset();
        run_frame(6'b000000, 6'd0);

        // Deferred startOfFrame during a commit
        do_new_game();
        step(6'b000001, 1'b0, 1'b0);
        step(6'd0, 1'b1, 1'b0);
        step(6'b000100, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b0);
        step(6'd0, 1'b1, 1'b0);
        step(6'b001000, 1'b0, 1'b0);
        check("deferred_first_score", score, 'h0005);
        check("deferred_busy_T+5", busy, 1);
        step(6'd0, 1'b0, 1'b0);
        check("deferred_idle_T+6", busy, 0);
        step(6'd0, 1'b0, 1'b0);
        check("deferred_busy_T+7", busy, 1);
        repeat (4) step(6'd0, 1'b0, 1'b0);
        check("deferred_second_score", score, 'h0017);
        step(6'd0, 1'b0, 1'b0);
        check("deferred_second_lives", lives, 4);
        check("deferred_done_busy", busy, 0);
        m_score = 17;
        m_lives = 4;
        m_go    = 1'b0;
        m_flags = 6'd0;

        // Losing the last life, then everything ignored
        do_new_game();
        run_frame(6'b000001, 6'd0);
        run_frame(6'b000010, 6'd0);
        run_frame(6'b000010, 6'd0);
        check("one_life_left", lives, 1);
        run_frame(6'b110000, 6'd0);
        check("gameover_lives", lives, 0);
        check("gameover_flag", gameOver, 1);
        run_frame(6'b001111, 6'd0);
        check("gameover_score_frozen", score, 'h0005);
        check("gameover_lives_frozen", lives, 0);

        // Preset to 9995, then saturate with a credit frame
        do_new_game();
        for (int i = 0; i < 1427; i++) run_frame(6'b000101, 6'd0);
        for (int i = 0; i < 3; i++) run_frame(6'b000100, 6'd0);
        check("preset_score", score, 'h9995);
        check("preset_lives", lives, 3);
        run_frame(6'b001000, 6'd0);
        check("saturated_score", score, 'h9999);
        check("saturated_lives", lives, 4);

        // Randomized frames against the model
        do_new_game();
        for (int f = 0; f < 80; f++) begin
            if (m_go) do_new_game();
            mask = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
            sofP = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            run_frame(mask, sofP);
        end

        // Reset mid-commit discards the partial score
        do_new_game();
        step(6'b001101, 1'b0, 1'b0);
        step(6'd0, 1'b1, 1'b0);
        step(6'd0, 1'b0, 1'b0);
        resetN = 1'b0;
        step(6'd0, 1'b0, 1'b0);
        resetN = 1'b1;
        check("midreset_score", score, 0);
        check("midreset_lives", lives, 3);
        check("midreset_busy", busy, 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire
